// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between writeback and a buffered MDU result FIFO
module wb_port_arbiter #(
  parameter int XLEN = 32,
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            mdu_valid,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_result,
  output logic            mdu_ready,
  input  logic [4:0]      rs1_q,
  input  logic [4:0]      rs2_q,
  output logic            pend_hit,
  output logic            stall_req,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [XLEN-1:0] rf_wd
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [3:0] AGE_TRIP = 4'(STARVE_LIMIT - 1);
  logic [4:0] rd_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0] count_q, count_d;
  logic [3:0] age_q, age_d;
  logic stall_q, stall_d, ready_q, ready_d;
  logic busy, empty, push, pop, head_we;
  logic [4:0] head_rd;
  logic [XLEN-1:0] head_data;
  assign busy = RegWriteW && RdW != 5'd0;
  assign empty = count_q == '0;
  assign push = mdu_valid && ready_q;
  // a reset cycle must not retire a head entry that is about to be discarded
  assign pop = !busy && !empty && !reset;
  assign head_rd = rd_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign head_we = pop && head_rd != 5'd0;
  assign rf_we = busy || head_we;
  assign rf_a3 = busy ? RdW : head_we ? head_rd : 5'd0;
  assign rf_wd = busy ? ResultW : head_we ? head_data : '0;
  assign mdu_ready = ready_q;
  assign stall_req = stall_q;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    age_d = (pop || empty) ? 4'd0 : (busy && age_q != 4'hf) ? age_q + 4'd1 : age_q;
    stall_d = (pop || empty) ? 1'b0 : (busy && age_q == AGE_TRIP) ? 1'b1 : stall_q;
    ready_d = count_d < CNT_FULL;
  end
  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if ({1'b0, PW'(PW'(i) - rd_ptr_q)} < count_q && rd_q[i] != 5'd0 &&
          (rd_q[i] == rs1_q || rd_q[i] == rs2_q))
        pend_hit = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      age_q <= 4'd0;
      stall_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      age_q <= age_d;
      stall_q <= stall_d;
      ready_q <= ready_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q] <= mdu_rd;
      data_q[wr_ptr_q] <= mdu_result;
    end
  end
endmodule
